// File: rtl/ptmch_pkg.sv
// Shared types and constants for the trigger-pulse scan controller.
package ptmch_pkg;

  localparam int NSRC_C = 5;

  localparam logic [2:0] SRC_PRGEXCT = 3'd0;
  localparam logic [2:0] SRC_RDSTAT  = 3'd1;
  localparam logic [2:0] SRC_BLKERS  = 3'd2;
  localparam logic [2:0] SRC_PDREAD  = 3'd3;
  localparam logic [2:0] SRC_WRSTAT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WINDOW,
    ST_SNAP,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/ptmch_scan_ctrl_next_src.sv
// Combinational search for the next enabled source above the current index,
// wrapping modulo NSRC; wrap_o flags that the search passed the top index.
module ptmch_next_src
  import ptmch_pkg::*;
#(
  parameter int NSRC = NSRC_C
) (
  input  logic [NSRC-1:0] mask_i,
  input  logic [2:0]      cur_i,
  output logic [2:0]      nxt_o,
  output logic            wrap_o
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    nxt_o  = cur_i;
    wrap_o = 1'b1;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NSRC; i++) begin
      idx = 3'((int'(cur_i) + i) % NSRC);
      if (!found && mask_i[idx]) begin
        found  = 1'b1;
        nxt_o  = idx;
        wrap_o = ((int'(cur_i) + i) >= NSRC);
      end
    end
  end

endmodule

// File: rtl/ptmch_scan_ctrl.sv
// Scan controller: steps the counter-block select through enabled sources,
// counts PLS_RISE over a dwell window per source and hands out snapshots.
module ptmch_scan_ctrl
  import ptmch_pkg::*;
#(
  parameter int NSRC    = NSRC_C,
  parameter int DWELL_W = 16,
  parameter int SETTLE  = 2
) (
  input  logic               CLK100M,
  input  logic               RESET,
  input  logic               START,
  input  logic               STOP,
  input  logic               CONT,
  input  logic [NSRC-1:0]    SRC_MASK,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               PLS_RISE,
  input  logic [7:0]         PADDR_CNT,
  output logic [2:0]         PAGEADDR_SEL,
  output logic               BUSY,
  output logic               SNAP_VLD,
  input  logic               SNAP_RDY,
  output logic [2:0]         SNAP_SEL,
  output logic [7:0]         SNAP_CNT,
  output logic [7:0]         SNAP_HITS,
  output logic               DONE,
  output logic               CFG_ERR
);

  state_e             state_q, state_d;
  logic [2:0]         sel_q;
  logic               cont_q;
  logic [NSRC-1:0]    mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [7:0]         hits_q;
  logic [7:0]         hits_nxt;
  logic [2:0]         snap_sel_q;
  logic [7:0]         snap_cnt_q;
  logic [7:0]         snap_hits_q;
  logic               done_q;
  logic               cfg_err_q;

  logic [2:0]         nxt_idx;
  logic               nxt_wrap;
  logic               settle_end;
  logic               win_end;
  logic               finish;

  function automatic logic [2:0] lowest_src(input logic [NSRC-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  ptmch_next_src #(.NSRC(NSRC)) u_next_src (
    .mask_i (mask_q),
    .cur_i  (sel_q),
    .nxt_o  (nxt_idx),
    .wrap_o (nxt_wrap)
  );

  assign settle_end = (cnt_q == DWELL_W'(SETTLE - 1));
  assign win_end    = (cnt_q == dwell_q - DWELL_W'(1));
  assign finish     = nxt_wrap && !cont_q;
  assign hits_nxt   = (PLS_RISE && hits_q != 8'hFF) ? hits_q + 8'd1 : hits_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (START && (|SRC_MASK)) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_end) state_d = ST_WINDOW;
      ST_WINDOW: if (win_end) state_d = ST_SNAP;
      ST_SNAP:   if (SNAP_RDY) state_d = ST_NEXT;
      ST_NEXT:   state_d = finish ? ST_IDLE : ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase
    // Abort has priority over every other transition.
    if (STOP) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK100M) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      sel_q       <= '0;
      cont_q      <= 1'b0;
      mask_q      <= '0;
      dwell_q     <= DWELL_W'(1);
      cnt_q       <= '0;
      hits_q      <= '0;
      snap_sel_q  <= '0;
      snap_cnt_q  <= '0;
      snap_hits_q <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (START && !STOP) begin
            if (|SRC_MASK) begin
              cont_q  <= CONT;
              mask_q  <= SRC_MASK;
              dwell_q <= (DWELL == '0) ? DWELL_W'(1) : DWELL;
              sel_q   <= lowest_src(SRC_MASK);
              cnt_q   <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            cnt_q  <= '0;
            hits_q <= '0;
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
        ST_WINDOW: begin
          hits_q <= hits_nxt;
          cnt_q  <= cnt_q + DWELL_W'(1);
          // The final-cycle pulse is folded into the captured count.
          if (win_end) begin
            snap_sel_q  <= sel_q;
            snap_cnt_q  <= PADDR_CNT;
            snap_hits_q <= hits_nxt;
          end
        end
        ST_NEXT: begin
          cnt_q  <= '0;
          done_q <= finish && !STOP;
          if (!STOP && !finish) sel_q <= nxt_idx;
        end
        default: ;
      endcase
    end
  end

  assign PAGEADDR_SEL = sel_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign SNAP_VLD     = (state_q == ST_SNAP);
  assign SNAP_SEL     = snap_sel_q;
  assign SNAP_CNT     = snap_cnt_q;
  assign SNAP_HITS    = snap_hits_q;
  assign DONE         = done_q;
  assign CFG_ERR      = cfg_err_q;

endmodule

// File: tb/tb_ptmch_scan_ctrl.sv
// Self-checking bench for ptmch_scan_ctrl: table-driven single-pass scans
// with a snapshot scoreboard, plus stall, continuous/stop and error sequences.
module tb_ptmch_scan_ctrl;

  logic        CLK100M = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        CONT = 1'b0;
  logic [4:0]  SRC_MASK = '0;
  logic [15:0] DWELL = '0;
  logic        PLS_RISE = 1'b0;
  logic [7:0]  PADDR_CNT;
  logic        SNAP_RDY = 1'b1;
  logic [2:0]  PAGEADDR_SEL;
  logic        BUSY;
  logic        SNAP_VLD;
  logic [2:0]  SNAP_SEL;
  logic [7:0]  SNAP_CNT;
  logic [7:0]  SNAP_HITS;
  logic        DONE;
  logic        CFG_ERR;

  ptmch_scan_ctrl dut (
    .CLK100M      (CLK100M),
    .RESET        (RESET),
    .START        (START),
    .STOP         (STOP),
    .CONT         (CONT),
    .SRC_MASK     (SRC_MASK),
    .DWELL        (DWELL),
    .PLS_RISE     (PLS_RISE),
    .PADDR_CNT    (PADDR_CNT),
    .PAGEADDR_SEL (PAGEADDR_SEL),
    .BUSY         (BUSY),
    .SNAP_VLD     (SNAP_VLD),
    .SNAP_RDY     (SNAP_RDY),
    .SNAP_SEL     (SNAP_SEL),
    .SNAP_CNT     (SNAP_CNT),
    .SNAP_HITS    (SNAP_HITS),
    .DONE         (DONE),
    .CFG_ERR      (CFG_ERR)
  );

  always #5 CLK100M = ~CLK100M;

  // Cycle number doubles as the counter-block byte, so SNAP_CNT pins the capture cycle.
  int cyc = 0;
  always @(posedge CLK100M) begin
    #1;
    cyc++;
  end
  assign PADDR_CNT = cyc[7:0];

  typedef struct {
    logic [2:0] sel;
    int         cnt;
    int         hits;
  } snap_t;

  typedef struct {
    logic [4:0]  mask;
    logic [15:0] dwell;
    logic [15:0] pat;
    bit          pls_all;
    bit          noise;
    int          h0;
    int          hn;
  } vec_t;

  snap_t sb_q[$];
  vec_t  vecs[7];
  int    n_vec = 0;
  int    n_err = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    vld_cyc = -1;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge CLK100M) begin : mon
    snap_t e;
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (SNAP_VLD && vld_cyc < 0) vld_cyc = cyc;
    if (SNAP_VLD && SNAP_RDY) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL snap_unexpected: got sel=%0d cnt=%0d hits=%0d, expected none (cycle %0d)",
                 SNAP_SEL, SNAP_CNT, SNAP_HITS, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("snap_sel", int'(SNAP_SEL), int'(e.sel));
        chk("snap_cnt", int'(SNAP_CNT), e.cnt & 255);
        chk("snap_hits", int'(SNAP_HITS), e.hits);
        $display("snap sel=%0d cnt=%0d hits=%0d at cycle %0d", SNAP_SEL, SNAP_CNT, SNAP_HITS, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK100M);
    #2;
  endtask

  task automatic start_scan(input logic [4:0] mask, input logic [15:0] dwell, input logic cont);
    done_cnt = 0;
    done_cyc = -1;
    vld_cyc  = -1;
    SRC_MASK = mask;
    DWELL    = dwell;
    CONT     = cont;
    START    = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},     int'(PAGEADDR_SEL), 0);
    chk({tag, "_busy"},    int'(BUSY), 0);
    chk({tag, "_vld"},     int'(SNAP_VLD), 0);
    chk({tag, "_ssel"},    int'(SNAP_SEL), 0);
    chk({tag, "_scnt"},    int'(SNAP_CNT), 0);
    chk({tag, "_shits"},   int'(SNAP_HITS), 0);
    chk({tag, "_done"},    int'(DONE), 0);
    chk({tag, "_cfg_err"}, int'(CFG_ERR), 0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int deff, s, n, r, j, budget;
    snap_t e;
    deff = (v.dwell == 0) ? 1 : int'(v.dwell);
    SNAP_RDY = 1'b1;
    s = cyc;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (v.mask[i]) begin
        e.sel  = 3'(i);
        e.cnt  = s + 2 + deff + n * (deff + 4);
        e.hits = (n == 0) ? v.h0 : v.hn;
        sb_q.push_back(e);
        n++;
      end
    end
    start_scan(v.mask, v.dwell, 1'b0);
    budget = n * (deff + 4) + 20;
    for (int t = 0; t < budget && done_cnt == 0; t++) begin
      r = cyc - s - 3;
      if (r < 0) begin
        PLS_RISE = v.noise;
      end else begin
        j = r % (deff + 4);
        if (j < deff)
          PLS_RISE = v.pls_all ? 1'b1 : ((r / (deff + 4)) == 0 && j < 16 && ((v.pat >> j) & 16'd1) != 0);
        else
          PLS_RISE = v.noise;
      end
      tick();
    end
    PLS_RISE = 1'b0;
    chk("vec_first_vld", vld_cyc, s + 3 + deff);
    chk("vec_done_cyc", done_cyc, s + 5 + deff + (n - 1) * (deff + 4));
    repeat (3) tick();
    chk("vec_done_count", done_cnt, 1);
    chk("vec_busy_end", int'(BUSY), 0);
    chk("vec_sb_empty", sb_q.size(), 0);
    $display("vector %0d mask=%b dwell=%0d applied, %0d snapshots", id, v.mask, v.dwell, n);
  endtask

  initial begin
    int s, t;
    snap_t e;

    vecs[0] = '{5'b00101, 16'd4,   16'h0005, 1'b0, 1'b0, 2,   0};
    vecs[1] = '{5'b00010, 16'd0,   16'h0001, 1'b0, 1'b1, 1,   0};
    vecs[2] = '{5'b11111, 16'd3,   16'h0007, 1'b0, 1'b1, 3,   0};
    vecs[3] = '{5'b01000, 16'd400, 16'h0000, 1'b1, 1'b0, 255, 255};
    vecs[4] = '{5'b11000, 16'd254, 16'h0000, 1'b1, 1'b1, 254, 254};
    vecs[5] = '{5'b10010, 16'd16,  16'hFFFF, 1'b0, 1'b1, 16,  0};
    vecs[6] = '{5'b00001, 16'd1,   16'h0000, 1'b0, 1'b1, 0,   0};

    repeat (3) tick();
    chk_reset_vals("reset");
    RESET = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Consumer stall: snapshot must hold while SNAP_RDY is low.
    SNAP_RDY = 1'b0;
    s = cyc;
    e = '{3'd1, s + 4, 0};
    sb_q.push_back(e);
    start_scan(5'b00110, 16'd2, 1'b0);
    for (int k = 0; k < 20 && !SNAP_VLD; k++) tick();
    chk("stall_vld_cyc", cyc, s + 5);
    for (int k = 0; k < 20; k++) begin
      chk("stall_vld",  int'(SNAP_VLD), 1);
      chk("stall_ssel", int'(SNAP_SEL), 1);
      chk("stall_scnt", int'(SNAP_CNT), (s + 4) & 255);
      chk("stall_hits", int'(SNAP_HITS), 0);
      chk("stall_psel", int'(PAGEADDR_SEL), 1);
      tick();
    end
    t = cyc;
    e = '{3'd2, t + 5, 0};
    sb_q.push_back(e);
    SNAP_RDY = 1'b1;
    for (int k = 0; k < 30 && done_cnt == 0; k++) tick();
    chk("stall_done", done_cnt, 1);
    chk("stall_sb_empty", sb_q.size(), 0);
    $display("stall sequence applied");

    // Continuous scan of one source, then abort mid-window.
    s = cyc;
    for (int k = 0; k < 3; k++) begin
      e = '{3'd4, s + 5 + 7 * k, 0};
      sb_q.push_back(e);
    end
    start_scan(5'b10000, 16'd3, 1'b1);
    while (cyc < s + 25) tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("stop_busy", int'(BUSY), 0);
    chk("stop_vld", int'(SNAP_VLD), 0);
    chk("stop_psel", int'(PAGEADDR_SEL), 4);
    chk("stop_sb_empty", sb_q.size(), 0);
    for (int k = 0; k < 10; k++) begin
      chk("stop_idle_vld", int'(SNAP_VLD), 0);
      tick();
    end
    chk("cont_no_done", done_cnt, 0);
    $display("continuous/stop sequence applied");

    // Empty mask start.
    start_scan(5'b00000, 16'd5, 1'b0);
    chk("cfg_err_pulse", int'(CFG_ERR), 1);
    chk("cfg_err_busy", int'(BUSY), 0);
    tick();
    chk("cfg_err_clear", int'(CFG_ERR), 0);
    chk("cfg_err_busy2", int'(BUSY), 0);
    $display("cfg_err sequence applied");

    // START while busy must be ignored.
    s = cyc;
    e = '{3'd0, s + 7, 0};
    sb_q.push_back(e);
    start_scan(5'b00001, 16'd5, 1'b0);
    tick();
    SRC_MASK = 5'b00010;
    DWELL    = 16'd1;
    CONT     = 1'b1;
    START    = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 40 && done_cnt == 0; k++) tick();
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_done_cyc", done_cyc, s + 10);
    chk("busy_start_sb_empty", sb_q.size(), 0);
    $display("start-while-busy sequence applied");

    // Reset while a snapshot is pending.
    SNAP_RDY = 1'b0;
    start_scan(5'b00100, 16'd1, 1'b0);
    for (int k = 0; k < 10 && !SNAP_VLD; k++) tick();
    chk("rst_pre_vld", int'(SNAP_VLD), 1);
    RESET = 1'b1;
    tick();
    chk_reset_vals("midrst");
    RESET = 1'b0;
    SNAP_RDY = 1'b1;
    tick();
    chk("midrst_busy_after", int'(BUSY), 0);
    $display("reset-mid-snap sequence applied");

    chk("final_sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
